// File: rtl/display_sequencer.sv
// Sequencer for the note-highway display: full-grid clear, then per-beat shift + redraw of 3 note boxes.
// Latency: clear pixel plots 2 cycles after loadDefault; box pixel plots 4 cycles after issue.
// No backpressure: one pixel per cycle; FLUSH drains the datapath pipeline before the next phase.
//
// Ports:
//   clock, reset (sync, active-high), start (level), beatTick (1-cycle pulse)
//   shiftSong, loadDefault, writeDefault, loadX/loadY, writeToScreen, songDone : datapath strobes
//   gridCounter[15:0] (bit 15 tied 0), boxCounter[1:0], pixelCount[14:0] : datapath indices
//   plot : VGA write enable; busy : high outside IDLE
//   beatOverrun : sticky, present only when DISPLAY_SEQ_BEAT_OVERRUN_EN is defined
// Optional feature macro: DISPLAY_SEQ_BEAT_OVERRUN_EN (queue one beat that lands mid-draw).
module display_sequencer #(
  parameter logic [14:0] CLEAR_LAST = 15'd32767,
  parameter logic [14:0] BOX_LAST   = 15'd7679,
  parameter logic [7:0]  SONG_BEATS = 8'd4,
  parameter logic [1:0]  NUM_BOXES  = 2'd3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        beatTick,
  output logic        shiftSong,
  output logic        loadDefault,
  output logic        writeDefault,
  output logic        loadX,
  output logic        loadY,
  output logic        writeToScreen,
  output logic        songDone,
  output logic [15:0] gridCounter,
  output logic [1:0]  boxCounter,
  output logic [14:0] pixelCount,
  output logic        plot,
  output logic        busy
`ifdef DISPLAY_SEQ_BEAT_OVERRUN_EN
  ,
  output logic        beatOverrun
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT_BEAT, S_SHIFT, S_DRAW, S_FLUSH, S_DONE
  } state_t;

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  logic [14:0] grid_q, grid_d;
  logic [1:0]  box_q, box_d;
  logic [14:0] pix_q, pix_d;
  logic [7:0]  beats_q, beats_d;
  // draw_vld: [0] addr/colour regs, [1] currentAddress (loadX/Y), [2] writeToScreen, [3] plot
  logic [3:0]  draw_vld_q, draw_vld_d;
  // clr_vld: [0] writeDefault, [1] plot
  logic [1:0]  clr_vld_q, clr_vld_d;
  logic        issue;
  logic        pipe_busy;

`ifdef DISPLAY_SEQ_BEAT_OVERRUN_EN
  logic pend_q, pend_d;
  logic ovr_q, ovr_d;
  logic tick_mid;
`endif

  assign pipe_busy = (|draw_vld_q) | (|clr_vld_q);

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    grid_d      = grid_q;
    box_d       = box_q;
    pix_d       = pix_q;
    beats_d     = beats_q;
    shiftSong   = 1'b0;
    loadDefault = 1'b0;
    songDone    = 1'b0;
    issue       = 1'b0;
`ifdef DISPLAY_SEQ_BEAT_OVERRUN_EN
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    tick_mid = beatTick &&
               (state_q == S_SHIFT || state_q == S_DRAW || state_q == S_FLUSH);
    // A tick while already pending lands on the same flag and is effectively dropped.
    if (tick_mid) begin
      pend_d = 1'b1;
      ovr_d  = 1'b1;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          grid_d  = '0;
        end
      end
      S_CLEAR: begin
        loadDefault = 1'b1;
        if (grid_q == CLEAR_LAST) begin
          grid_d  = '0;
          ret_d   = S_WAIT_BEAT;
          state_d = S_FLUSH;
        end else begin
          grid_d = grid_q + 15'd1;
        end
      end
      S_WAIT_BEAT: begin
        if (beatTick) begin
          state_d = S_SHIFT;
        end
`ifdef DISPLAY_SEQ_BEAT_OVERRUN_EN
        // Covers a tick that arrived in the final FLUSH cycle.
        if (pend_q) begin
          state_d = S_SHIFT;
        end
        if (beatTick || pend_q) begin
          pend_d = 1'b0;
        end
`endif
      end
      S_SHIFT: begin
        shiftSong = 1'b1;
        beats_d   = beats_q + 8'd1;
        box_d     = '0;
        pix_d     = '0;
        state_d   = S_DRAW;
      end
      S_DRAW: begin
        issue = 1'b1;
        if (pix_q == BOX_LAST) begin
          if (box_q == NUM_BOXES - 2'd1) begin
            // Last pixel: indices hold while the pipeline drains.
            state_d = S_FLUSH;
            ret_d   = (beats_q == SONG_BEATS) ? S_DONE : S_WAIT_BEAT;
          end else begin
            pix_d = '0;
            box_d = box_q + 2'd1;
          end
        end else begin
          pix_d = pix_q + 15'd1;
        end
      end
      S_FLUSH: begin
        if (!pipe_busy) begin
          state_d = ret_q;
`ifdef DISPLAY_SEQ_BEAT_OVERRUN_EN
          if (ret_q == S_WAIT_BEAT && pend_q) begin
            state_d = S_SHIFT;
            pend_d  = 1'b0;
          end
`endif
        end
      end
      S_DONE: begin
        songDone = 1'b1;
        beats_d  = '0;
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_BEAT;
`ifdef DISPLAY_SEQ_BEAT_OVERRUN_EN
          if (pend_q) begin
            state_d = S_SHIFT;
            pend_d  = 1'b0;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    draw_vld_d = {draw_vld_q[2:0], issue};
    clr_vld_d  = {clr_vld_q[0], loadDefault};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ret_q      <= S_WAIT_BEAT;
      grid_q     <= '0;
      box_q      <= '0;
      pix_q      <= '0;
      beats_q    <= '0;
      draw_vld_q <= '0;
      clr_vld_q  <= '0;
`ifdef DISPLAY_SEQ_BEAT_OVERRUN_EN
      pend_q     <= 1'b0;
      ovr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      grid_q     <= grid_d;
      box_q      <= box_d;
      pix_q      <= pix_d;
      beats_q    <= beats_d;
      draw_vld_q <= draw_vld_d;
      clr_vld_q  <= clr_vld_d;
`ifdef DISPLAY_SEQ_BEAT_OVERRUN_EN
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
`endif
    end
  end

  assign writeDefault  = clr_vld_q[0];
  assign loadX         = draw_vld_q[1];
  assign loadY         = draw_vld_q[1];
  assign writeToScreen = draw_vld_q[2];
  assign plot          = clr_vld_q[1] | draw_vld_q[3];
  assign busy          = (state_q != S_IDLE);
  assign gridCounter   = {1'b0, grid_q};
  assign boxCounter    = box_q;
  assign pixelCount    = pix_q;
`ifdef DISPLAY_SEQ_BEAT_OVERRUN_EN
  assign beatOverrun   = ovr_q;
`endif

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- Controller for the note-highway display datapath. It sequences the full-grid default clear, then the per-beat cycle: shift the song registers, then redraw the three note boxes pixel by pixel.
- Generates every datapath strobe and counter, and produces the VGA plot enable aligned to the datapath's registered pipeline.
- Sits between the beat rate divider and the datapath/VGA adapter.

Parameters:
- CLEAR_LAST, 15'd32767, last gridCounter value of the clear pass (X = gridCounter[14:7], Y = gridCounter[6:0]).
- BOX_LAST, 15'd7679, last pixelCount value per box (60 columns x 128 rows, column-major).
- SONG_BEATS, 8'd4, beats per song before songDone.
- NUM_BOXES, 2'd3, boxes drawn per beat (boxCounter 0..NUM_BOXES-1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  level; begin clear + song when sampled high in IDLE
- beatTick  in  1  single-cycle beat pulse from rate divider
- shiftSong  out  1  one-cycle shift strobe to datapath
- loadDefault  out  1  load default X/Y/colour from gridCounter
- writeDefault  out  1  drive default registers onto VGA outputs
- loadX  out  1  load regX (always equal to loadY)
- loadY  out  1  load regY
- writeToScreen  out  1  drive box registers onto VGA outputs
- songDone  out  1  one-cycle pulse at song end; resets datapath note registers
- gridCounter  out  16  clear-pass pixel index (bit 15 always 0)
- boxCounter  out  2  current box select
- pixelCount  out  15  pixel index within box
- plot  out  1  VGA write enable, aligned with valid vgaOut*
- busy  out  1  high in every state except IDLE
- beatOverrun  out  1  sticky; present only with the optional feature

Behaviour:
- Reset (synchronous, takes priority in every state including mid-draw): state = IDLE; all counters = 0; all strobes, plot, busy and beatOverrun = 0; beat count = 0; pipeline valid bits cleared. Any pixels in flight are discarded.
- States: IDLE, CLEAR, WAIT_BEAT, SHIFT, DRAW, FLUSH, DONE.
- IDLE -> CLEAR when start = 1.
- CLEAR:
  - Each cycle asserts loadDefault with the current gridCounter, then increments gridCounter.
  - After the cycle with gridCounter = CLEAR_LAST: gridCounter returns to 0 and state -> FLUSH(ret = WAIT_BEAT).
- Clear pipeline: loadDefault at cycle t; writeDefault at t+1; plot at t+2.
- WAIT_BEAT: on beatTick = 1 -> SHIFT. beatTick in any other state is ignored (default build).
- SHIFT:
  - Asserts shiftSong for exactly 1 cycle.
  - Increments the beat count.
  - Sets boxCounter = 0, pixelCount = 0; -> DRAW.
- DRAW:
  - Issues one pixel per cycle (boxCounter, pixelCount).
  - pixelCount wraps BOX_LAST -> 0 and boxCounter increments.
  - After the pixel (NUM_BOXES-1, BOX_LAST) -> FLUSH(ret = WAIT_BEAT, or DONE if beat count = SONG_BEATS).
- Draw pipeline, matching the datapath's registered stages:
  - Issue at t: boxCounter/pixelCount valid at t.
  - Address/colour registered at t+1; currentAddress at t+2.
  - loadX = loadY = 1 at t+2; writeToScreen at t+3; plot at t+4.
  - A 4-deep valid shift register generates these strobes; boxCounter and pixelCount hold their last values while the pipeline drains.
- FLUSH: waits until the pipeline valid bits are all 0 (4 cycles after the last issue), then -> ret. No new issue during FLUSH.
- DONE:
  - songDone = 1 for 1 cycle; beat count = 0.
  - -> IDLE if start = 0; otherwise -> WAIT_BEAT (song repeats without re-clear).
- Strobe relations: shiftSong, loadDefault and loadX are mutually exclusive every cycle; writeDefault and writeToScreen are never high together; plot = delayed (writeDefault | writeToScreen).
- Widths: beat count 8 bits; the comparison against SONG_BEATS is exact, with no wrap. SONG_BEATS = 0 is illegal.

Optional Feature:
- Macro: DISPLAY_SEQ_BEAT_OVERRUN_EN.
- With the macro:
  - A beatTick arriving in SHIFT, DRAW or FLUSH sets a one-deep pending flag and the sticky beatOverrun.
  - On entry to WAIT_BEAT with the flag set, go directly to SHIFT and clear the flag.
  - A second tick while the flag is pending is dropped; beatOverrun stays 1.
  - Reset clears both.
- Without the macro: the beatOverrun port is absent and such ticks are discarded.

Test Plan:
- Reset, start = 1 -> 32768 loadDefault cycles with gridCounter 0..32767; plot count = 32768; first plot 2 cycles after the first loadDefault; busy = 1 throughout.
- After the clear, a beatTick pulse -> shiftSong high for exactly 1 cycle; then 3 x 7680 = 23040 plot pulses; boxCounter sequence 0, 1, 2; first plot 4 cycles after the first issue.
- 4 beats with start held -> songDone pulses once, immediately after the 4th draw's FLUSH; the 5th beatTick starts a new draw without a clear.
- Reset asserted mid-DRAW (pixelCount = 100) -> on the next cycle all outputs are 0, state = IDLE, and no further plot pulses occur.
- beatTick during DRAW (macro off) -> ignored; no shift until the next tick in WAIT_BEAT.
- Macro on, two ticks during DRAW -> beatOverrun = 1; exactly one extra SHIFT, immediately after FLUSH.
